// File: rtl/stopwatch_ctrl.sv
// Stopwatch time controller: 2 Hz / 1 Hz clock-enable time base, run/pause/adjust
// mode sequencing and the minute/second registers read directly by the display.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel,
  input  logic       adj,
  input  logic       pause_btn,
  input  logic       clr_btn,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       tick_2hz,
  output logic       tick_1hz
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = 6;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] MAX_VAL  = TW'(59);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_PAUSED  = 2'b01,
    MODE_ADJ_SEC = 2'b10,
    MODE_ADJ_MIN = 2'b11
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          half_q, half_d;
  logic          paused_q, paused_d;
  logic [TW-1:0] min_q, min_d;
  logic [TW-1:0] sec_q, sec_d;

  // Modulo-60 increment; anything at or above 59 folds back to zero.
  function automatic logic [TW-1:0] wrap_inc(input logic [TW-1:0] v);
    return (v >= MAX_VAL) ? '0 : v + TW'(1);
  endfunction

  // Time base enables are decoded from the registered prescaler state.
  assign tick_2hz = (pre_q == PRE_LAST);
  assign tick_1hz = tick_2hz & half_q;

  assign minutes = min_q;
  assign seconds = sec_q;
  assign mode    = mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_PAUSED;
      pre_q    <= '0;
      half_q   <= 1'b0;
      paused_q <= 1'b1;
      min_q    <= '0;
      sec_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      half_q   <= half_d;
      paused_q <= paused_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
    end
  end

  always_comb begin
    pre_d    = tick_2hz ? '0 : pre_q + PW'(1);
    half_d   = half_q ^ tick_2hz;
    paused_d = paused_q;
    mode_d   = mode_q;
    min_d    = min_q;
    sec_d    = sec_q;

    // Pause requests are only honoured outside adjust so the run state survives it.
    if (pause_btn && !adj) begin
      paused_d = ~paused_q;
    end

    if (adj) begin
      mode_d = sel ? MODE_ADJ_SEC : MODE_ADJ_MIN;
    end else begin
      mode_d = paused_d ? MODE_PAUSED : MODE_RUN;
    end

    unique case (mode_q)
      MODE_RUN: begin
        if (tick_1hz) begin
          if (sec_q >= MAX_VAL) begin
            sec_d = '0;
            min_d = wrap_inc(min_q);
          end else begin
            sec_d = sec_q + TW'(1);
          end
        end
      end
      MODE_ADJ_SEC: begin
        if (tick_2hz) begin
          sec_d = wrap_inc(sec_q);
        end
      end
      MODE_ADJ_MIN: begin
        if (tick_2hz) begin
          min_d = wrap_inc(min_q);
        end
      end
      default: begin
      end
    endcase

    // Clear overrides any same-cycle increment and restarts the time base phase.
    if (clr_btn) begin
      pre_d  = '0;
      half_d = 1'b0;
      min_d  = '0;
      sec_d  = '0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at TICK_DIV=4: each task walks one scenario
// from a known prescaler phase and checks hand-computed outputs.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       adj;
  logic       pause_btn;
  logic       clr_btn;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       tick_2hz;
  logic       tick_1hz;

  int total;
  int bad;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .adj       (adj),
    .pause_btn (pause_btn),
    .clr_btn   (clr_btn),
    .minutes   (minutes),
    .seconds   (seconds),
    .mode      (mode),
    .tick_2hz  (tick_2hz),
    .tick_1hz  (tick_1hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp2;
    logic exp1;
    rst = 1'b0; sel = 1'b0; adj = 1'b0; pause_btn = 1'b0; clr_btn = 1'b0;
    step(3);
    rst = 1'b1;
    total++;
    if ({minutes, seconds, mode, tick_2hz, tick_1hz} !== {6'd0, 6'd0, 2'b01, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got %0d:%0d mode=%b t2=%b t1=%b want 0:0 mode=01 t2=0 t1=0",
               minutes, seconds, mode, tick_2hz, tick_1hz);
    end
    for (int i = 0; i < 40; i++) begin
      exp2 = ((i % 4) == 3);
      exp1 = ((i % 8) == 7);
      total++;
      if (tick_2hz !== exp2 || tick_1hz !== exp1) begin
        bad++;
        $display("FAIL reset_ticks cyc=%0d: got t2=%b t1=%b want t2=%b t1=%b",
                 i, tick_2hz, tick_1hz, exp2, exp1);
      end
      step(1);
    end
    total++;
    if ({minutes, seconds, mode} !== {6'd0, 6'd0, 2'b01}) begin
      bad++;
      $display("FAIL reset_idle: got %0d:%0d mode=%b want 0:0 mode=01", minutes, seconds, mode);
    end
  endtask

  task automatic test_run();
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    total++;
    if (mode !== 2'b00) begin
      bad++; $display("FAIL run_mode: got %b want 00", mode);
    end
    step(486);
    total++;
    if ({minutes, seconds} !== {6'd1, 6'd0}) begin
      bad++; $display("FAIL run_60s: got %0d:%0d want 1:0", minutes, seconds);
    end
    step(1);
    total++;
    if ({minutes, seconds} !== {6'd1, 6'd1}) begin
      bad++; $display("FAIL run_61s: got %0d:%0d want 1:1", minutes, seconds);
    end
    clr_btn = 1'b1; adj = 1'b1; sel = 1'b1; step(1); clr_btn = 1'b0;
    step(236);
    total++;
    if ({minutes, seconds, mode} !== {6'd0, 6'd59, 2'b10}) begin
      bad++; $display("FAIL adj_to_59: got %0d:%0d mode=%b want 0:59 mode=10", minutes, seconds, mode);
    end
    adj = 1'b0; step(1); step(2);
    total++;
    if ({minutes, seconds, mode, tick_1hz} !== {6'd0, 6'd59, 2'b00, 1'b1}) begin
      bad++; $display("FAIL pre_carry: got %0d:%0d mode=%b t1=%b want 0:59 mode=00 t1=1",
                      minutes, seconds, mode, tick_1hz);
    end
    step(1);
    total++;
    if ({minutes, seconds} !== {6'd1, 6'd0}) begin
      bad++; $display("FAIL sec_carry: got %0d:%0d want 1:0", minutes, seconds);
    end
  endtask

  task automatic test_wrap();
    clr_btn = 1'b1; adj = 1'b1; sel = 1'b0; step(1); clr_btn = 1'b0;
    step(236);
    total++;
    if ({minutes, seconds} !== {6'd59, 6'd0}) begin
      bad++; $display("FAIL adj_min_59: got %0d:%0d want 59:0", minutes, seconds);
    end
    sel = 1'b1; step(1); step(235);
    total++;
    if ({minutes, seconds} !== {6'd59, 6'd59}) begin
      bad++; $display("FAIL at_5959: got %0d:%0d want 59:59", minutes, seconds);
    end
    adj = 1'b0; step(1); step(6);
    total++;
    if ({minutes, seconds, tick_1hz} !== {6'd59, 6'd59, 1'b1}) begin
      bad++; $display("FAIL pre_wrap: got %0d:%0d t1=%b want 59:59 t1=1", minutes, seconds, tick_1hz);
    end
    step(1);
    total++;
    if ({minutes, seconds, mode} !== {6'd0, 6'd0, 2'b00}) begin
      bad++; $display("FAIL full_wrap: got %0d:%0d mode=%b want 0:0 mode=00", minutes, seconds, mode);
    end
  endtask

  task automatic test_adjust();
    clr_btn = 1'b1; adj = 1'b1; sel = 1'b0; step(1); clr_btn = 1'b0;
    step(8);
    total++;
    if ({minutes, seconds} !== {6'd2, 6'd0}) begin
      bad++; $display("FAIL adj_min2: got %0d:%0d want 2:0", minutes, seconds);
    end
    sel = 1'b1; step(1); step(231);
    total++;
    if ({minutes, seconds, mode} !== {6'd2, 6'd58, 2'b10}) begin
      bad++; $display("FAIL adj_0258: got %0d:%0d mode=%b want 2:58 mode=10", minutes, seconds, mode);
    end
    step(8);
    total++;
    if ({minutes, seconds} !== {6'd2, 6'd0}) begin
      bad++; $display("FAIL adj_sec_wrap: got %0d:%0d want 2:0", minutes, seconds);
    end
    step(12);
    total++;
    if ({minutes, seconds} !== {6'd2, 6'd3}) begin
      bad++; $display("FAIL adj_0203: got %0d:%0d want 2:3", minutes, seconds);
    end
    sel = 1'b0; step(1);
    total++;
    if (mode !== 2'b11) begin
      bad++; $display("FAIL adj_sel_switch: got mode=%b want 11", mode);
    end
    step(11);
    total++;
    if ({minutes, seconds} !== {6'd5, 6'd3}) begin
      bad++; $display("FAIL adj_0503: got %0d:%0d want 5:3", minutes, seconds);
    end
    adj = 1'b0; step(1);
    total++;
    if (mode !== 2'b00) begin
      bad++; $display("FAIL adj_exit_run: got mode=%b want 00", mode);
    end
  endtask

  task automatic test_pause_in_adjust();
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    total++;
    if (mode !== 2'b01) begin
      bad++; $display("FAIL pause_mode: got %b want 01", mode);
    end
    adj = 1'b1; sel = 1'b1; pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    total++;
    if (mode !== 2'b10) begin
      bad++; $display("FAIL adj_enter: got %b want 10", mode);
    end
    step(2);
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    adj = 1'b0; step(1);
    total++;
    if ({minutes, seconds, mode} !== {6'd5, 6'd4, 2'b01}) begin
      bad++; $display("FAIL adj_exit_paused: got %0d:%0d mode=%b want 5:4 mode=01",
                      minutes, seconds, mode);
    end
    step(2);
    total++;
    if ({minutes, seconds} !== {6'd5, 6'd4}) begin
      bad++; $display("FAIL paused_hold: got %0d:%0d want 5:4", minutes, seconds);
    end
  endtask

  task automatic test_pause_on_tick();
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    step(5);
    total++;
    if ({tick_1hz, mode} !== {1'b1, 2'b00}) begin
      bad++; $display("FAIL pt_setup: got t1=%b mode=%b want t1=1 mode=00", tick_1hz, mode);
    end
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    total++;
    if ({minutes, seconds, mode} !== {6'd5, 6'd5, 2'b01}) begin
      bad++; $display("FAIL pause_tick: got %0d:%0d mode=%b want 5:5 mode=01", minutes, seconds, mode);
    end
    step(8);
    total++;
    if ({minutes, seconds} !== {6'd5, 6'd5}) begin
      bad++; $display("FAIL pause_tick_hold: got %0d:%0d want 5:5", minutes, seconds);
    end
  endtask

  task automatic test_clear_on_tick();
    clr_btn = 1'b1; step(1); clr_btn = 1'b0;
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    step(86);
    total++;
    if ({minutes, seconds, tick_1hz} !== {6'd0, 6'd10, 1'b1}) begin
      bad++; $display("FAIL clr_setup: got %0d:%0d t1=%b want 0:10 t1=1", minutes, seconds, tick_1hz);
    end
    clr_btn = 1'b1; step(1); clr_btn = 1'b0;
    total++;
    if ({minutes, seconds, mode} !== {6'd0, 6'd0, 2'b00}) begin
      bad++; $display("FAIL clr_wins: got %0d:%0d mode=%b want 0:0 mode=00", minutes, seconds, mode);
    end
    step(2);
    total++;
    if (tick_2hz !== 1'b0) begin
      bad++; $display("FAIL clr_phase_early: got t2=%b want 0", tick_2hz);
    end
    step(1);
    total++;
    if ({tick_2hz, tick_1hz} !== {1'b1, 1'b0}) begin
      bad++; $display("FAIL clr_phase: got t2=%b t1=%b want t2=1 t1=0", tick_2hz, tick_1hz);
    end
    step(1);
    total++;
    if (seconds !== 6'd0) begin
      bad++; $display("FAIL clr_half: got sec=%0d want 0", seconds);
    end
    step(4);
    total++;
    if ({minutes, seconds} !== {6'd0, 6'd1}) begin
      bad++; $display("FAIL clr_first_sec: got %0d:%0d want 0:1", minutes, seconds);
    end
  endtask

  task automatic test_reset_midrun();
    #3 rst = 1'b0;
    #1;
    total++;
    if ({minutes, seconds, mode, tick_2hz, tick_1hz} !== {6'd0, 6'd0, 2'b01, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_reset: got %0d:%0d mode=%b t2=%b t1=%b want 0:0 mode=01 t2=0 t1=0",
                      minutes, seconds, mode, tick_2hz, tick_1hz);
    end
    step(2);
    rst = 1'b1;
    step(20);
    total++;
    if ({minutes, seconds, mode} !== {6'd0, 6'd0, 2'b01}) begin
      bad++; $display("FAIL post_reset_idle: got %0d:%0d mode=%b want 0:0 mode=01", minutes, seconds, mode);
    end
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    step(3);
    total++;
    if ({minutes, seconds, mode} !== {6'd0, 6'd1, 2'b00}) begin
      bad++; $display("FAIL post_reset_run: got %0d:%0d mode=%b want 0:1 mode=00", minutes, seconds, mode);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_run();
    test_wrap();
    test_adjust();
    test_pause_in_adjust();
    test_pause_on_tick();
    test_clear_on_tick();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Single-clock controller for the stopwatch time datapath.
- Generates the 2 Hz and 1 Hz time base as clock enables; no derived clocks.
- Sequences run/pause/adjust modes and owns the minute and second registers.
- Carry, wrap and adjust-freeze rules are all resolved inside this block; the display path reads minutes/seconds directly.

Parameters:
- TICK_DIV, 50000000, clk cycles per 2 Hz tick (must be >= 2; bench uses 4).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- sel  in  1  adjust target: 1 = seconds, 0 = minutes (level)
- adj  in  1  adjust mode enable (level, pre-synchronised)
- pause_btn  in  1  single-cycle pulse, toggles run/pause (debounced upstream)
- clr_btn  in  1  single-cycle pulse, synchronous clear of time
- minutes  out  6  current minutes, 0..59
- seconds  out  6  current seconds, 0..59
- mode  out  2  00 RUN, 01 PAUSED, 10 ADJ_SEC, 11 ADJ_MIN
- tick_2hz  out  1  one-cycle pulse every TICK_DIV cycles
- tick_1hz  out  1  one-cycle pulse on every second tick_2hz

Behaviour:
- Reset (rst=0, async):
  - minutes=0, seconds=0, prescaler=0, half=0.
  - paused flag=1, mode=PAUSED, tick outputs 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, wraps to 0.
  - tick_2hz=1 in the cycle prescaler==TICK_DIV-1.
  - half toggles on each tick_2hz.
  - tick_1hz = tick_2hz & half (first 1 Hz tick at the 2nd 2 Hz tick after reset/clear).
  - Ticks are combinational from the registered count; they run in all modes.
- Mode FSM (registered; adj/sel sampled each edge; new mode visible the next cycle):
  - Any state, adj=1, sel=1 -> ADJ_SEC.
  - Any state, adj=1, sel=0 -> ADJ_MIN.
  - adj=0 -> RUN if paused flag=0, else PAUSED.
  - sel changes while adj=1 switch between ADJ_SEC and ADJ_MIN next cycle.
- Paused flag:
  - pause_btn with adj=0 toggles the flag.
  - pause_btn with adj=1 is ignored; the flag is preserved across adjust, so leaving adjust returns to the prior run/pause state.
- Time update (uses the mode register value of the current cycle; result visible the cycle after the tick):
  - RUN, tick_1hz:
    - seconds<59 -> seconds+1.
    - seconds==59 -> seconds=0 and minutes+1 (59 wraps to 0); 59:59 -> 00:00.
  - PAUSED: no change.
  - ADJ_SEC, tick_2hz: seconds+1, 59 -> 0, no carry into minutes; minutes frozen.
  - ADJ_MIN, tick_2hz: minutes+1, 59 -> 0; seconds frozen.
- clr_btn:
  - Next cycle: minutes=0, seconds=0, prescaler=0, half=0.
  - Paused flag and mode unchanged.
  - clr_btn in the same cycle as a tick: clear wins, no increment.
- Simultaneous pause_btn and tick in RUN: the increment still happens; mode goes to PAUSED next cycle.
- Arithmetic: 6-bit unsigned. Values never exceed 59; the 60..63 encodings are unreachable.
- Reset asserted mid-count or mid-adjust: immediate return to reset values; counting resumes only after a pause_btn.

Test Plan (TICK_DIV=4):
- Reset, hold 40 cycles, no buttons -> mode=01, time 00:00, tick_2hz every 4 cycles, tick_1hz every 8.
- pause_btn once, run 8*61 cycles -> mode=00, time 01:01; force seconds to 59 via adjust, then resume -> 00:59 -> 01:00 on next tick_1hz.
- RUN at 59:59, next tick_1hz -> 00:00, no spurious carry.
- adj=1, sel=1 for 5 tick_2hz at 02:58 -> 02:03 (wrap 59->0, minutes stay 02); then sel=0 for 3 ticks -> 05:03; adj=0 -> mode=00 if previously RUN, 01 if PAUSED.
- pause_btn pulsed during adj=1 -> ignored; after adj=0, mode equals the pre-adjust mode.
- clr_btn coincident with tick_1hz at 00:10 -> 00:00 next cycle, prescaler restarts (next tick_2hz 4 cycles later); rst low mid-run -> outputs zero asynchronously, mode=01.
